spi_slave_tx_sched: RTL

SPI_SLAVE_TX_SCHED -- requirements
Module: spi_slave_tx_sched

---
 rtl/spi_slave_tx_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_tx_sched.sv
// Feeds an SPI slave's TX word from two prioritised request ports and
// forwards each received word together with the source of the word it replaced.
module spi_slave_tx_sched #(
  parameter int unsigned       WORD_W     = 18,
  parameter logic [WORD_W-1:0] IDLE_WORD  = '0,
  parameter int unsigned       STARVE_MAX = 3
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_REQ0_Valid,
  input  logic [WORD_W-1:0] i_REQ0_Word,
  output logic              o_REQ0_Ready,
  input  logic              i_REQ1_Valid,
  input  logic [WORD_W-1:0] i_REQ1_Word,
  output logic              o_REQ1_Ready,
  output logic              o_SLV_TX_DV,
  output logic [WORD_W-1:0] o_SLV_TX_Word,
  input  logic              i_SLV_RX_DV,
  input  logic [WORD_W-1:0] i_SLV_RX_Word,
  input  logic              i_SPI_CS_n,
  output logic              o_RX_DV,
  output logic [WORD_W-1:0] o_RX_Word,
  output logic [1:0]        o_RX_Src,
  output logic              o_Abort,
  output logic              o_Underrun,
  input  logic              i_Clr_Status,
  output logic [15:0]       o_Word_Cnt
);

  localparam int unsigned     SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [1:0]      SRC_IDLE   = 2'd2;
  localparam logic [1:0]      SRC_NONE   = 2'd3;

  typedef enum logic {ST_IDLE, ST_ARMED} state_e;

  state_e            state_q, state_d;
  logic              csMeta_q, csSync_q, csPrev_q;
  logic [SW-1:0]     starve_q, starve_d;
  logic [1:0]        tag_q, tag_d;
  logic              txDv_q, txDv_d;
  logic [WORD_W-1:0] txWord_q, txWord_d;
  logic              rxDv_q, rxDv_d;
  logic [WORD_W-1:0] rxWord_q, rxWord_d;
  logic [1:0]        rxSrc_q, rxSrc_d;
  logic              abort_q, abort_d;
  logic              underrun_q, underrun_d;
  logic [15:0]       wordCnt_q, wordCnt_d;

  logic csRise, portOneTurn, grant0, grant1, isIdle;

  // Ready is withheld during reset so no handshake completes before release.
  assign isIdle      = (state_q == ST_IDLE) && i_Rst_L;
  assign csRise      = csSync_q && !csPrev_q;
  assign portOneTurn = i_REQ1_Valid && (starve_q == STARVE_LIM);
  assign grant0      = isIdle && i_REQ0_Valid && !portOneTurn;
  assign grant1      = isIdle && i_REQ1_Valid && (!i_REQ0_Valid || portOneTurn);

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    tag_d      = tag_q;
    txDv_d     = 1'b0;
    txWord_d   = txWord_q;
    rxDv_d     = 1'b0;
    rxWord_d   = rxWord_q;
    rxSrc_d    = rxSrc_q;
    abort_d    = 1'b0;
    underrun_d = i_Clr_Status ? 1'b0 : underrun_q;
    wordCnt_d  = i_Clr_Status ? 16'd0 : wordCnt_q;

    if (!i_REQ1_Valid || grant1) begin
      starve_d = '0;
    end else if (grant0 && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (grant0) begin
          txDv_d   = 1'b1;
          txWord_d = i_REQ0_Word;
          tag_d    = 2'd0;
          state_d  = ST_ARMED;
        end else if (grant1) begin
          txDv_d   = 1'b1;
          txWord_d = i_REQ1_Word;
          tag_d    = 2'd1;
          state_d  = ST_ARMED;
        end else if (!i_REQ0_Valid && !i_REQ1_Valid && !csSync_q) begin
          // Master is clocking with nothing queued: keep the slave fed.
          txDv_d     = 1'b1;
          txWord_d   = IDLE_WORD;
          tag_d      = SRC_IDLE;
          underrun_d = 1'b1;
          state_d    = ST_ARMED;
        end
        if (i_SLV_RX_DV) begin
          rxDv_d    = 1'b1;
          rxWord_d  = i_SLV_RX_Word;
          rxSrc_d   = SRC_NONE;
          wordCnt_d = wordCnt_d + 16'd1;
        end
      end
      ST_ARMED: begin
        if (i_SLV_RX_DV) begin
          rxDv_d    = 1'b1;
          rxWord_d  = i_SLV_RX_Word;
          rxSrc_d   = tag_q;
          wordCnt_d = wordCnt_d + 16'd1;
          state_d   = ST_IDLE;
        end else if (csRise) begin
          abort_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q    <= ST_IDLE;
      csMeta_q   <= 1'b1;
      csSync_q   <= 1'b1;
      csPrev_q   <= 1'b1;
      starve_q   <= '0;
      tag_q      <= 2'd0;
      txDv_q     <= 1'b0;
      txWord_q   <= '0;
      rxDv_q     <= 1'b0;
      rxWord_q   <= '0;
      rxSrc_q    <= 2'd0;
      abort_q    <= 1'b0;
      underrun_q <= 1'b0;
      wordCnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      csMeta_q   <= i_SPI_CS_n;
      csSync_q   <= csMeta_q;
      csPrev_q   <= csSync_q;
      starve_q   <= starve_d;
      tag_q      <= tag_d;
      txDv_q     <= txDv_d;
      txWord_q   <= txWord_d;
      rxDv_q     <= rxDv_d;
      rxWord_q   <= rxWord_d;
      rxSrc_q    <= rxSrc_d;
      abort_q    <= abort_d;
      underrun_q <= underrun_d;
      wordCnt_q  <= wordCnt_d;
    end
  end

  assign o_REQ0_Ready  = grant0;
  assign o_REQ1_Ready  = grant1;
  assign o_SLV_TX_DV   = txDv_q;
  assign o_SLV_TX_Word = txWord_q;
  assign o_RX_DV       = rxDv_q;
  assign o_RX_Word     = rxWord_q;
  assign o_RX_Src      = rxSrc_q;
  assign o_Abort       = abort_q;
  assign o_Underrun    = underrun_q;
  assign o_Word_Cnt    = wordCnt_q;

endmodule
